// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM states, requester IDs and a
// helper that maps a read winner to the state that waits for its data.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_IF  = 2'd1,
        WAIT_LSU = 2'd2
    } mem_arb_state_t;

    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_LSU = 1'b1
    } req_id_t;

    // Wait state that owns the outstanding read of the given requester.
    function automatic mem_arb_state_t wait_state(input req_id_t id);
        return (id == REQ_IF) ? WAIT_IF : WAIT_LSU;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester and memory-side signals around the arbiter.
// Handshake rules: a read request (x_ren) is held high with a stable
// address until the matching x_rvalid pulse; a write request (lsu_wen)
// is held with stable addr/data until lsu_wready is seen in the same cycle;
// mem_ren is a one-cycle issue pulse answered later by a one-cycle
// mem_rvalid; mem_wen is a one-cycle write with no response.
interface mem_arbiter_if #(
    parameter int DATA_W = 64
) ();
    logic              if_ren;
    logic [DATA_W-1:0] if_raddr;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              lsu_ren;
    logic [DATA_W-1:0] lsu_raddr;
    logic              lsu_rvalid;
    logic [DATA_W-1:0] lsu_rdata;

    logic              lsu_wen;
    logic [DATA_W-1:0] lsu_waddr;
    logic [DATA_W-1:0] lsu_wdata;
    logic              lsu_wready;

    logic              mem_ren;
    logic [DATA_W-1:0] mem_raddr;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    logic              mem_wen;
    logic [DATA_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Arbiter side
    modport slave (
        input  if_ren, if_raddr, lsu_ren, lsu_raddr,
        input  lsu_wen, lsu_waddr, lsu_wdata,
        input  mem_rvalid, mem_rdata,
        output if_rvalid, if_rdata, lsu_rvalid, lsu_rdata, lsu_wready,
        output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata
    );

    // Requesters plus memory (environment) side
    modport master (
        output if_ren, if_raddr, lsu_ren, lsu_raddr,
        output lsu_wen, lsu_waddr, lsu_wdata,
        output mem_rvalid, mem_rdata,
        input  if_rvalid, if_rdata, lsu_rvalid, lsu_rdata, lsu_wready,
        input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick between fetch and LSU read requests.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic    req_if_i,
    input  logic    req_lsu_i,
    input  req_id_t last_i,
    output logic    gnt_valid_o,
    output req_id_t gnt_id_o
);

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        gnt_valid_o = req_if_i | req_lsu_i;
        gnt_id_o    = REQ_IF;
        if (req_if_i && req_lsu_i) begin
            gnt_id_o = (last_i == REQ_IF) ? REQ_LSU : REQ_IF;
        end else if (req_lsu_i) begin
            gnt_id_o = REQ_LSU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch reads, LSU reads and LSU writes onto one memory port.
// Only one read may be outstanding; writes are combinational pass-through
// in IDLE and stall while a read is waiting for its data.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   arb_if,
    output mem_arb_state_t state_o
);

    mem_arb_state_t state_q, state_d;
    req_id_t        rr_last_q, rr_last_d;
    logic           wr_last_q, wr_last_d;

    logic           gnt_valid;
    req_id_t        gnt_id;
    logic           rd_pend;

    logic              if_rvalid, lsu_rvalid, lsu_wready, mem_ren, mem_wen;
    logic [DATA_W-1:0] if_rdata, lsu_rdata, mem_raddr, mem_waddr, mem_wdata;

    assign rd_pend = arb_if.if_ren | arb_if.lsu_ren;

    rr_arb2 u_rr_arb2 (
        .req_if_i    (arb_if.if_ren),
        .req_lsu_i   (arb_if.lsu_ren),
        .last_i      (rr_last_q),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    // State, round-robin and write-fairness registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            rr_last_q <= REQ_LSU;
            wr_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            wr_last_q <= wr_last_d;
        end
    end

    // Next state and all outputs; everything is forced to 0 while in reset.
    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        wr_last_d  = wr_last_q;
        if_rvalid  = 1'b0;
        if_rdata   = '0;
        lsu_rvalid = 1'b0;
        lsu_rdata  = '0;
        lsu_wready = 1'b0;
        mem_ren    = 1'b0;
        mem_raddr  = '0;
        mem_wen    = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    // Write wins unless it won last time while a read waited.
                    if (arb_if.lsu_wen && !(wr_last_q && rd_pend)) begin
                        mem_wen    = 1'b1;
                        lsu_wready = 1'b1;
                        mem_waddr  = arb_if.lsu_waddr;
                        mem_wdata  = arb_if.lsu_wdata;
                        if (rd_pend) begin
                            wr_last_d = 1'b1;
                        end
                    end else if (gnt_valid) begin
                        mem_ren   = 1'b1;
                        mem_raddr = (gnt_id == REQ_IF) ? arb_if.if_raddr : arb_if.lsu_raddr;
                        rr_last_d = gnt_id;
                        wr_last_d = 1'b0;
                        state_d   = wait_state(gnt_id);
                    end
                end
                WAIT_IF: begin
                    if (arb_if.mem_rvalid) begin
                        if_rvalid = 1'b1;
                        if_rdata  = arb_if.mem_rdata;
                        state_d   = IDLE;
                    end
                end
                WAIT_LSU: begin
                    if (arb_if.mem_rvalid) begin
                        lsu_rvalid = 1'b1;
                        lsu_rdata  = arb_if.mem_rdata;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign arb_if.if_rvalid  = if_rvalid;
    assign arb_if.if_rdata   = if_rdata;
    assign arb_if.lsu_rvalid = lsu_rvalid;
    assign arb_if.lsu_rdata  = lsu_rdata;
    assign arb_if.lsu_wready = lsu_wready;
    assign arb_if.mem_ren    = mem_ren;
    assign arb_if.mem_raddr  = mem_raddr;
    assign arb_if.mem_wen    = mem_wen;
    assign arb_if.mem_waddr  = mem_waddr;
    assign arb_if.mem_wdata  = mem_wdata;
    assign state_o           = rst ? state_q : IDLE;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change on the falling edge and
// outputs are sampled 1ns later, so each falling edge is one arbiter cycle.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int DW = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    mem_arb_state_t state;
    int             checks = 0;
    int             errors = 0;

    mem_arbiter_if #(.DATA_W(DW)) bus ();

    mem_arbiter #(.DATA_W(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .arb_if  (bus.slave),
        .state_o (state)
    );

    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.if_ren     = 1'b0; bus.if_raddr  = '0;
        bus.lsu_ren    = 1'b0; bus.lsu_raddr = '0;
        bus.lsu_wen    = 1'b0; bus.lsu_waddr = '0; bus.lsu_wdata = '0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        bus.if_ren = 1'b1; bus.if_raddr = 64'h10;
        bus.lsu_wen = 1'b1; bus.lsu_waddr = 64'h20; bus.lsu_wdata = 64'h30;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h40;
        @(negedge clk); @(negedge clk); #1;
        checks++; if (state !== IDLE) begin errors++; $display("FAIL rst_state act=%0d exp=%0d", state, IDLE); end
        checks++; if (bus.mem_ren !== 1'b0) begin errors++; $display("FAIL rst_mem_ren act=%0b exp=0", bus.mem_ren); end
        checks++; if (bus.mem_wen !== 1'b0) begin errors++; $display("FAIL rst_mem_wen act=%0b exp=0", bus.mem_wen); end
        checks++; if (bus.lsu_wready !== 1'b0) begin errors++; $display("FAIL rst_wready act=%0b exp=0", bus.lsu_wready); end
        checks++; if (bus.mem_waddr !== 64'h0) begin errors++; $display("FAIL rst_waddr act=%0h exp=0", bus.mem_waddr); end
        checks++; if (bus.if_rvalid !== 1'b0 || bus.lsu_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid act=%0b%0b exp=00", bus.if_rvalid, bus.lsu_rvalid); end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
    endtask

    task automatic test_single_read();
        apply_reset();
        @(negedge clk);
        bus.if_ren = 1'b1; bus.if_raddr = 64'h1000; #1;
        checks++; if (bus.mem_ren !== 1'b1) begin errors++; $display("FAIL rd_issue act=%0b exp=1", bus.mem_ren); end
        checks++; if (bus.mem_raddr !== 64'h1000) begin errors++; $display("FAIL rd_addr act=%0h exp=1000", bus.mem_raddr); end
        @(negedge clk);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hDEAD; #1;
        checks++; if (state !== WAIT_IF) begin errors++; $display("FAIL rd_wait_state act=%0d exp=%0d", state, WAIT_IF); end
        checks++; if (bus.mem_ren !== 1'b0) begin errors++; $display("FAIL rd_one_pulse act=%0b exp=0", bus.mem_ren); end
        checks++; if (bus.if_rvalid !== 1'b1) begin errors++; $display("FAIL rd_if_rvalid act=%0b exp=1", bus.if_rvalid); end
        checks++; if (bus.if_rdata !== 64'hDEAD) begin errors++; $display("FAIL rd_if_rdata act=%0h exp=dead", bus.if_rdata); end
        checks++; if (bus.lsu_rvalid !== 1'b0) begin errors++; $display("FAIL rd_lsu_rvalid act=%0b exp=0", bus.lsu_rvalid); end
        @(negedge clk);
        idle_inputs();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hBEEF; #1;
        checks++; if (state !== IDLE) begin errors++; $display("FAIL rd_back_idle act=%0d exp=%0d", state, IDLE); end
        checks++; if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 64'h0) begin errors++; $display("FAIL rd_idle_rvalid act=%0b/%0h exp=0/0", bus.if_rvalid, bus.if_rdata); end
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_round_robin();
        logic exp_if;
        apply_reset();
        @(negedge clk);
        bus.if_ren = 1'b1; bus.if_raddr = 64'h100;
        bus.lsu_ren = 1'b1; bus.lsu_raddr = 64'h200;
        for (int i = 0; i < 4; i++) begin
            exp_if = (i % 2 == 0);
            #1;
            checks++; if (bus.mem_ren !== 1'b1) begin errors++; $display("FAIL rr_issue%0d act=%0b exp=1", i, bus.mem_ren); end
            checks++; if (bus.mem_raddr !== (exp_if ? 64'h100 : 64'h200)) begin errors++; $display("FAIL rr_order%0d act=%0h exp=%0h", i, bus.mem_raddr, exp_if ? 64'h100 : 64'h200); end
            @(negedge clk);
            bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hA0 + 64'(i); #1;
            checks++; if (bus.if_rvalid !== exp_if || bus.lsu_rvalid !== !exp_if) begin errors++; $display("FAIL rr_rvalid%0d act=%0b%0b exp=%0b%0b", i, bus.if_rvalid, bus.lsu_rvalid, exp_if, !exp_if); end
            checks++; if ((exp_if ? bus.if_rdata : bus.lsu_rdata) !== 64'hA0 + 64'(i)) begin errors++; $display("FAIL rr_rdata%0d act=%0h/%0h exp=%0h", i, bus.if_rdata, bus.lsu_rdata, 64'hA0 + 64'(i)); end
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
        end
        idle_inputs();
    endtask

    task automatic test_write();
        apply_reset();
        @(negedge clk);
        bus.lsu_wen = 1'b1; bus.lsu_waddr = 64'h2000; bus.lsu_wdata = 64'h55; #1;
        checks++; if (bus.mem_wen !== 1'b1 || bus.lsu_wready !== 1'b1) begin errors++; $display("FAIL wr_accept act=%0b%0b exp=11", bus.mem_wen, bus.lsu_wready); end
        checks++; if (bus.mem_waddr !== 64'h2000 || bus.mem_wdata !== 64'h55) begin errors++; $display("FAIL wr_addr_data act=%0h/%0h exp=2000/55", bus.mem_waddr, bus.mem_wdata); end
        checks++; if (bus.mem_ren !== 1'b0) begin errors++; $display("FAIL wr_no_read act=%0b exp=0", bus.mem_ren); end
        @(negedge clk);
        idle_inputs(); #1;
        checks++; if (bus.mem_wen !== 1'b0 || bus.mem_waddr !== 64'h0 || bus.mem_wdata !== 64'h0) begin errors++; $display("FAIL wr_idle_zero act=%0b/%0h/%0h exp=0/0/0", bus.mem_wen, bus.mem_waddr, bus.mem_wdata); end
    endtask

    task automatic test_write_read_fairness();
        apply_reset();
        @(negedge clk);
        bus.if_ren = 1'b1; bus.if_raddr = 64'h1100;
        for (int k = 0; k < 3; k++) begin
            bus.lsu_wen = 1'b1; bus.lsu_waddr = 64'h3000 + 64'(k * 8); bus.lsu_wdata = 64'(k + 1); #1;
            checks++; if (bus.mem_wen !== 1'b1 || bus.mem_ren !== 1'b0) begin errors++; $display("FAIL fair_write%0d act=wen%0b ren%0b exp=wen1 ren0", k, bus.mem_wen, bus.mem_ren); end
            checks++; if (bus.mem_waddr !== 64'h3000 + 64'(k * 8)) begin errors++; $display("FAIL fair_waddr%0d act=%0h exp=%0h", k, bus.mem_waddr, 64'h3000 + 64'(k * 8)); end
            if (k == 2) break;
            @(negedge clk); #1;
            checks++; if (bus.mem_ren !== 1'b1 || bus.mem_wen !== 1'b0 || bus.lsu_wready !== 1'b0) begin errors++; $display("FAIL fair_read%0d act=ren%0b wen%0b rdy%0b exp=ren1 wen0 rdy0", k, bus.mem_ren, bus.mem_wen, bus.lsu_wready); end
            checks++; if (bus.mem_raddr !== 64'h1100) begin errors++; $display("FAIL fair_raddr%0d act=%0h exp=1100", k, bus.mem_raddr); end
            @(negedge clk);
            bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hC0 + 64'(k); #1;
            checks++; if (bus.if_rvalid !== 1'b1 || bus.mem_wen !== 1'b0) begin errors++; $display("FAIL fair_return%0d act=rv%0b wen%0b exp=rv1 wen0", k, bus.if_rvalid, bus.mem_wen); end
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_write_stall();
        apply_reset();
        @(negedge clk);
        bus.lsu_ren = 1'b1; bus.lsu_raddr = 64'h4000; #1;
        checks++; if (bus.mem_ren !== 1'b1 || bus.mem_raddr !== 64'h4000) begin errors++; $display("FAIL stall_issue act=%0b/%0h exp=1/4000", bus.mem_ren, bus.mem_raddr); end
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            bus.lsu_wen = 1'b1; bus.lsu_waddr = 64'h5000; bus.lsu_wdata = 64'h77;
            if (i == 5) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h1234; end
            #1;
            checks++; if (bus.lsu_wready !== 1'b0 || bus.mem_wen !== 1'b0) begin errors++; $display("FAIL stall_wait%0d act=rdy%0b wen%0b exp=rdy0 wen0", i, bus.lsu_wready, bus.mem_wen); end
            checks++; if (bus.lsu_rvalid !== (i == 5)) begin errors++; $display("FAIL stall_rvalid%0d act=%0b exp=%0b", i, bus.lsu_rvalid, i == 5); end
        end
        checks++; if (bus.lsu_rdata !== 64'h1234) begin errors++; $display("FAIL stall_rdata act=%0h exp=1234", bus.lsu_rdata); end
        @(negedge clk);
        bus.mem_rvalid = 1'b0; bus.lsu_ren = 1'b0; #1;
        checks++; if (bus.lsu_wready !== 1'b1 || bus.mem_waddr !== 64'h5000 || bus.mem_wdata !== 64'h77) begin errors++; $display("FAIL stall_accept act=%0b/%0h/%0h exp=1/5000/77", bus.lsu_wready, bus.mem_waddr, bus.mem_wdata); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_during_wait();
        apply_reset();
        @(negedge clk);
        bus.if_ren = 1'b1; bus.if_raddr = 64'h6000; #1;
        checks++; if (bus.mem_ren !== 1'b1) begin errors++; $display("FAIL rw_issue act=%0b exp=1", bus.mem_ren); end
        @(negedge clk); #1;
        checks++; if (state !== WAIT_IF) begin errors++; $display("FAIL rw_wait act=%0d exp=%0d", state, WAIT_IF); end
        @(negedge clk);
        rst = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h99; #1;
        checks++; if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 64'h0) begin errors++; $display("FAIL rw_in_reset act=%0b/%0h exp=0/0", bus.if_rvalid, bus.if_rdata); end
        @(negedge clk);
        rst = 1'b1; bus.if_ren = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hBAD; #1;
        checks++; if (bus.if_rvalid !== 1'b0 || bus.lsu_rvalid !== 1'b0) begin errors++; $display("FAIL rw_late_rvalid act=%0b%0b exp=00", bus.if_rvalid, bus.lsu_rvalid); end
        checks++; if (state !== IDLE) begin errors++; $display("FAIL rw_state act=%0d exp=%0d", state, IDLE); end
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.if_ren = 1'b1; bus.if_raddr = 64'h7000;
        bus.lsu_ren = 1'b1; bus.lsu_raddr = 64'h8000; #1;
        checks++; if (bus.mem_ren !== 1'b1 || bus.mem_raddr !== 64'h7000) begin errors++; $display("FAIL rw_tie_fetch act=%0b/%0h exp=1/7000", bus.mem_ren, bus.mem_raddr); end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_write_read_fairness();
        test_write_stall();
        test_reset_during_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
